lfsr_rng: RTL and testbench
===========================

Name: lfsr_rng

Overview:
- Parametrised Galois-LFSR pseudo-random source. It is the next generation of the fixed 13-bit LFSR that drives the board LEDs.
- Adds configurable width, tap mask, seed, decimation and output width.
- Adds a runtime seed load, all-zero lock-up recovery, and a valid/ready output port with overrun counting.
- Sits between the top level and any consumer: the LED display (ready tied high) or a UART/packetiser.

Parameters:
- WIDTH, 13, LFSR state width in bits (2..32).
- TAPS, 13'h100D, Galois feedback mask. Bit WIDTH-1 must be set. The default gives a maximal-length period of 8191.
- SEED, 13'h0001, reset and lock-up recovery state. Must be non-zero.
- OUT_BITS, 5, sample width taken from the state LSBs (1..WIDTH).
- STEPS, 1, LFSR steps per emitted sample (1..2^16).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  advance LFSR one step per cycle while high
- seed_load  in  1  load seed_in into the state this cycle
- seed_in  in  WIDTH  seed value for seed_load
- rnd_data  out  OUT_BITS  sample payload
- rnd_valid  out  1  sample available
- rnd_ready  in  1  consumer accepts the sample
- lockup  out  1  one-cycle pulse: an all-zero state was replaced by SEED
- overrun  out  8  saturating count of dropped samples
- state_out  out  WIDTH  current LFSR state (debug)

Behaviour:
- Reset (synchronous, reset high at posedge clk):
  - state = SEED; step counter = 0.
  - rnd_data = 0, rnd_valid = 0, lockup = 0, overrun = 0.
  - Reset overrides all other inputs and aborts any pending sample or count.
- Step function: next = (state >> 1) ^ (state[0] ? TAPS : 0), truncated to WIDTH bits.
- Priority each cycle:
  - seed_load first, then en, otherwise hold.
  - seed_load: state = seed_in and step counter = 0. No step and no sample that cycle. rnd_valid and rnd_data are unaffected.
  - If seed_in == 0: state = SEED instead, and lockup pulses high for the next cycle only.
  - en high with no seed_load: state = next; step counter increments.
- Sample point:
  - Occurs on the step where counter == STEPS-1. The counter wraps to 0.
  - Capture rnd_data = next[OUT_BITS-1:0] (the post-step state) and set rnd_valid = 1. This is one register of latency from the step.
- Handshake:
  - A transfer occurs when rnd_valid and rnd_ready are both high at the edge.
  - Without a new sample, a transfer clears rnd_valid.
  - A sample point coinciding with a transfer loads the new sample and keeps rnd_valid = 1 (back-to-back throughput).
  - rnd_data stays stable while rnd_valid = 1 and rnd_ready = 0.
- Overrun: a sample point while rnd_valid = 1 and rnd_ready = 0:
  - The new sample is dropped and the old one is kept.
  - overrun increments, saturating at 255. Only reset clears it.
- Lock-up guard: if state is ever 0 (defensive; unreachable with a valid TAPS), the next cycle loads SEED instead of stepping and pulses lockup.
- en low: state, counter and outputs hold. The handshake still operates.
- state_out = state register, no extra latency.

Test Plan:
- Default parameters, reset for 2 cycles then en = 1, rnd_ready = 1:
  - state_out sequence is 0x0001, 0x100D, 0x180B, 0x1C08.
  - rnd_data is 0x0D, 0x0B, 0x08 with rnd_valid high from the first step.
  - After 8191 steps state_out returns to 0x0001 and no earlier repeat occurs.
- STEPS = 4, OUT_BITS = 5:
  - rnd_valid rises exactly every 4th en cycle.
  - rnd_data equals state_out[4:0] after that step.
  - With en toggled 1-0-1-0, samples arrive only after 4 enabled cycles.
- Backpressure: rnd_ready = 0 for 10 steps with STEPS = 1:
  - The first sample holds stable and overrun reads 9.
  - Raising rnd_ready gives one transfer, then a fresh sample every cycle.
  - Holding ready low for 300 samples makes overrun saturate at 255.
- seed_load with seed_in = 0x0ABC during en:
  - state_out becomes 0x0ABC and the counter restarts.
  - The next step gives 0x055E.
- seed_load with seed_in = 0:
  - state_out becomes 0x0001 and lockup is high for exactly one cycle.
  - Stepping then resumes normally.
- Reset mid-stream with rnd_valid = 1 and overrun = 5:
  - One cycle later rnd_valid = 0, overrun = 0, state_out = 0x0001 and rnd_data = 0.
  - The first sample after release matches the post-reset sequence.

Source files
------------

// File: rtl/lfsr_rng.sv
// -----------------------------------------------------------------------------
// lfsr_rng : parametrised Galois-LFSR pseudo-random sample source.
//
// The LFSR advances one step per cycle while en is high. Every STEPS steps the
// post-step state's OUT_BITS LSBs are captured into an output register and
// offered on a valid/ready port. A runtime seed can be loaded, and an all-zero
// state (which would lock a Galois LFSR forever) is replaced by SEED.
//
// Handshake: rnd_data is held stable while rnd_valid is high. A transfer
// happens on any rising clk edge where rnd_valid and rnd_ready are both high.
// A new sample arriving while the held sample is not being taken is dropped
// and counted in overrun.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   en           advance the LFSR one step this cycle
//   seed_load    load seed_in into the state (takes priority over en)
//   seed_in      seed value; zero is replaced by SEED and flagged on lockup
//   rnd_data     sample payload (OUT_BITS wide)
//   rnd_valid    sample available
//   rnd_ready    consumer accepts the sample
//   lockup       one-cycle pulse: an all-zero state was replaced by SEED
//   overrun      saturating count of dropped samples, cleared only by reset
//   state_out    current LFSR state (debug)
// -----------------------------------------------------------------------------
module lfsr_rng #(
   parameter int                WIDTH    = 13,
   parameter logic [WIDTH-1:0]  TAPS     = 13'h100D,
   parameter logic [WIDTH-1:0]  SEED     = 13'h0001,
   parameter int                OUT_BITS = 5,
   parameter int                STEPS    = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                seed_load,
   input  logic [WIDTH-1:0]    seed_in,
   output logic [OUT_BITS-1:0] rnd_data,
   output logic                rnd_valid,
   input  logic                rnd_ready,
   output logic                lockup,
   output logic [7:0]          overrun,
   output logic [WIDTH-1:0]    state_out
);

   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

   logic [WIDTH-1:0]    state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [OUT_BITS-1:0] data_q, data_d;
   logic                valid_q, valid_d;
   logic                lockup_q, lockup_d;
   logic [7:0]          overrun_q, overrun_d;

   logic [WIDTH-1:0]    step_val;
   logic                sample_pt;
   logic                xfer;

   // Galois step: shift right, fold the taps in when the bit shifted out is 1.
   assign step_val = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
   assign xfer     = valid_q & rnd_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lockup_d  = 1'b0;
      sample_pt = 1'b0;

      if (seed_load) begin
         // A seed load never steps and never produces a sample.
         cnt_d = '0;
         if (seed_in == '0) begin
            state_d  = SEED;
            lockup_d = 1'b1;
         end else begin
            state_d = seed_in;
         end
      end else if (state_q == '0) begin
         // Defensive recovery: zero is a fixed point of the step function.
         state_d  = SEED;
         lockup_d = 1'b1;
      end else if (en) begin
         state_d = step_val;
         if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            sample_pt = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;

      if (sample_pt) begin
         if (valid_q && !rnd_ready) begin
            // Held sample not taken: keep it, drop the new one.
            if (overrun_q != 8'hFF) begin
               overrun_d = overrun_q + 8'd1;
            end
         end else begin
            // Either the slot is empty or it empties this edge.
            data_d  = step_val[OUT_BITS-1:0];
            valid_d = 1'b1;
         end
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SEED;
         cnt_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         lockup_q  <= 1'b0;
         overrun_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         lockup_q  <= lockup_d;
         overrun_q <= overrun_d;
      end
   end

   assign rnd_data  = data_q;
   assign rnd_valid = valid_q;
   assign lockup    = lockup_q;
   assign overrun   = overrun_q;
   assign state_out = state_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// -----------------------------------------------------------------------------
// tb_lfsr_rng : bench for lfsr_rng.
// Two instances: u0 with default parameters (STEPS = 1) and u1 with STEPS = 4.
// A reference model per instance tracks the LFSR value, steps since the last
// sample and a one-deep sample slot (exp_q); it is checked every cycle.
// Directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_lfsr_rng;

   localparam int W  = 13;
   localparam int OB = 5;
   localparam logic [W-1:0] TAPS_P = 13'h100D;
   localparam logic [W-1:0] SEED_P = 13'h0001;
   localparam int STEPS_P [2] = '{1, 4};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // per-instance stimulus
   logic          rst_s [2];
   logic          en_s [2];
   logic          sl_s [2];
   logic [W-1:0]  seed_s [2];
   logic          rdy_s [2];

   // per-instance DUT outputs
   logic [OB-1:0] data_o [2];
   logic          valid_o [2];
   logic          lock_o [2];
   logic [7:0]    ovr_o [2];
   logic [W-1:0]  st_o [2];

   lfsr_rng #(.WIDTH(W), .TAPS(TAPS_P), .SEED(SEED_P), .OUT_BITS(OB), .STEPS(1)) u0 (
      .clk(clk), .reset(rst_s[0]), .en(en_s[0]), .seed_load(sl_s[0]), .seed_in(seed_s[0]),
      .rnd_data(data_o[0]), .rnd_valid(valid_o[0]), .rnd_ready(rdy_s[0]),
      .lockup(lock_o[0]), .overrun(ovr_o[0]), .state_out(st_o[0]));

   lfsr_rng #(.WIDTH(W), .TAPS(TAPS_P), .SEED(SEED_P), .OUT_BITS(OB), .STEPS(4)) u1 (
      .clk(clk), .reset(rst_s[1]), .en(en_s[1]), .seed_load(sl_s[1]), .seed_in(seed_s[1]),
      .rnd_data(data_o[1]), .rnd_valid(valid_o[1]), .rnd_ready(rdy_s[1]),
      .lockup(lock_o[1]), .overrun(ovr_o[1]), .state_out(st_o[1]));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0]  m_st [2];
   int            m_steps [2];
   int            m_ovr [2];
   logic          m_lock [2];
   logic          m_init [2] = '{1'b0, 1'b0};
   logic [OB-1:0] exp_q [2][$];

   function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
      if (s[0]) return (s >> 1) ^ TAPS_P;
      return s >> 1;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst_s[i]) begin
            m_st[i]    = SEED_P;
            m_steps[i] = 0;
            m_ovr[i]   = 0;
            m_lock[i]  = 1'b0;
            exp_q[i].delete();
            m_init[i]  = 1'b1;
         end else if (m_init[i]) begin
            logic sample;
            logic taken;
            sample    = 1'b0;
            taken     = (exp_q[i].size() > 0) && rdy_s[i];
            m_lock[i] = 1'b0;
            if (sl_s[i]) begin
               m_steps[i] = 0;
               if (seed_s[i] == '0) begin
                  m_st[i]   = SEED_P;
                  m_lock[i] = 1'b1;
               end else begin
                  m_st[i] = seed_s[i];
               end
            end else if (m_st[i] == '0) begin
               m_st[i]   = SEED_P;
               m_lock[i] = 1'b1;
            end else if (en_s[i]) begin
               m_st[i] = lfsr_next(m_st[i]);
               m_steps[i]++;
               if (m_steps[i] == STEPS_P[i]) begin
                  m_steps[i] = 0;
                  sample     = 1'b1;
               end
            end
            if (taken) void'(exp_q[i].pop_front());
            if (sample) begin
               if (exp_q[i].size() > 0) begin
                  if (m_ovr[i] < 255) m_ovr[i]++;
               end else begin
                  exp_q[i].push_back(m_st[i][OB-1:0]);
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (m_init[i]) begin
            chk($sformatf("u%0d state", i), int'(st_o[i]), int'(m_st[i]));
            chk($sformatf("u%0d valid", i), int'(valid_o[i]), int'(exp_q[i].size() > 0));
            if (exp_q[i].size() > 0)
               chk($sformatf("u%0d data", i), int'(data_o[i]), int'(exp_q[i][0]));
            chk($sformatf("u%0d overrun", i), int'(ovr_o[i]), m_ovr[i]);
            chk($sformatf("u%0d lockup", i), int'(lock_o[i]), int'(m_lock[i]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int i);
      en_s[i] = 1'b0; sl_s[i] = 1'b0; seed_s[i] = '0; rdy_s[i] = 1'b0;
   endtask

   task automatic do_reset(input int i, input int cycles);
      idle(i);
      rst_s[i] = 1'b1;
      repeat (cycles) tick();
      rst_s[i] = 1'b0;
   endtask

   logic [W-1:0]  seq_st [4] = '{13'h0001, 13'h100D, 13'h180B, 13'h1C08};
   logic [OB-1:0] seq_dt [4] = '{5'h00, 5'h0D, 5'h0B, 5'h08};

   initial begin
      int n;
      int nv;
      int first_v;
      idle(0); idle(1);
      rst_s[0] = 1'b0; rst_s[1] = 1'b0;

      // Reset state, then the head of the default sequence.
      rst_s[0] = 1'b1; rst_s[1] = 1'b1;
      tick(); tick();
      rst_s[0] = 1'b0; rst_s[1] = 1'b0;
      chk("rst state", int'(st_o[0]), 'h0001);
      chk("rst valid", int'(valid_o[0]), 0);
      chk("rst data", int'(data_o[0]), 0);
      chk("rst overrun", int'(ovr_o[0]), 0);
      chk("rst lockup", int'(lock_o[0]), 0);
      en_s[0] = 1'b1; rdy_s[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("seq state", int'(st_o[0]), int'(seq_st[k]));
         if (k > 0) begin
            chk("seq valid", int'(valid_o[0]), 1);
            chk("seq data", int'(data_o[0]), int'(seq_dt[k]));
         end
         if (k < 3) tick();
      end

      // seed_load 0x0ABC during en, then one step.
      sl_s[0] = 1'b1; seed_s[0] = 13'h0ABC;
      tick();
      sl_s[0] = 1'b0;
      chk("seed state", int'(st_o[0]), 'h0ABC);
      tick();
      chk("seed step", int'(st_o[0]), 'h055E);

      // seed_load with zero: recovery to SEED and a one-cycle lockup pulse.
      sl_s[0] = 1'b1; seed_s[0] = '0;
      tick();
      sl_s[0] = 1'b0; en_s[0] = 1'b0;
      chk("zero seed state", int'(st_o[0]), 'h0001);
      chk("zero seed lockup", int'(lock_o[0]), 1);
      tick();
      chk("lockup cleared", int'(lock_o[0]), 0);
      en_s[0] = 1'b1;
      tick();
      chk("resume step", int'(st_o[0]), 'h100D);

      // Full period from SEED.
      do_reset(0, 1);
      en_s[0] = 1'b1; rdy_s[0] = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (st_o[0] != 13'h0001 && n < 9000);
      chk("period", n, 8191);

      // Backpressure: 10 steps with ready low.
      do_reset(0, 1);
      en_s[0] = 1'b1;
      tick();
      chk("bp first data", int'(data_o[0]), 'h0D);
      repeat (9) tick();
      chk("bp held data", int'(data_o[0]), 'h0D);
      chk("bp valid", int'(valid_o[0]), 1);
      chk("bp overrun", int'(ovr_o[0]), 9);
      rdy_s[0] = 1'b1;
      repeat (5) tick();
      chk("bp overrun kept", int'(ovr_o[0]), 9);

      // Saturation.
      do_reset(0, 1);
      en_s[0] = 1'b1;
      repeat (300) tick();
      chk("overrun sat", int'(ovr_o[0]), 255);

      // Reset mid-stream with overrun = 5.
      do_reset(0, 1);
      en_s[0] = 1'b1;
      repeat (6) tick();
      chk("mid overrun", int'(ovr_o[0]), 5);
      rst_s[0] = 1'b1;
      tick();
      rst_s[0] = 1'b0;
      chk("mid rst valid", int'(valid_o[0]), 0);
      chk("mid rst overrun", int'(ovr_o[0]), 0);
      chk("mid rst state", int'(st_o[0]), 'h0001);
      chk("mid rst data", int'(data_o[0]), 0);
      rdy_s[0] = 1'b1;
      tick();
      chk("post rst data", int'(data_o[0]), 'h0D);
      chk("post rst valid", int'(valid_o[0]), 1);
      en_s[0] = 1'b0;

      // STEPS = 4: one sample per 4 enabled cycles.
      do_reset(1, 1);
      en_s[1] = 1'b1; rdy_s[1] = 1'b1;
      nv = 0; first_v = 0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (valid_o[1]) begin
            nv++;
            if (first_v == 0) begin
               first_v = k;
               chk("s4 first data", int'(data_o[1]), 'h04);
            end
         end
      end
      chk("s4 sample count", nv, 4);
      chk("s4 first sample", first_v, 4);

      // STEPS = 4 with en toggled 1-0-1-0.
      do_reset(1, 1);
      rdy_s[1] = 1'b1;
      nv = 0;
      for (int k = 1; k <= 7; k++) begin
         en_s[1] = k[0];
         tick();
         if (k < 7 && valid_o[1]) nv++;
      end
      en_s[1] = 1'b0;
      chk("s4 toggle early", nv, 0);
      chk("s4 toggle valid", int'(valid_o[1]), 1);
      chk("s4 toggle data", int'(data_o[1]), 'h04);
      tick();

      // STEPS = 4: seed_load restarts the step count.
      do_reset(1, 1);
      en_s[1] = 1'b1; rdy_s[1] = 1'b1;
      tick(); tick();
      sl_s[1] = 1'b1; seed_s[1] = 13'h0ABC;
      tick();
      sl_s[1] = 1'b0;
      nv = 0;
      repeat (3) begin
         tick();
         if (valid_o[1]) nv++;
      end
      chk("s4 restart early", nv, 0);
      tick();
      chk("s4 restart valid", int'(valid_o[1]), 1);
      chk("s4 restart data", int'(data_o[1]), 'h0D);
      en_s[1] = 1'b0;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
